// File: rtl/muldiv_seq_if.sv
// HI/LO mul/div sequencer bus: EX-stage operands and handshake toward muldiv_seq.
interface muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             id_hilo_use;
  logic             busy;
  logic             stall;
  logic             hilo_we;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  // Pipeline side: drives the request, observes the result.
  modport master (
    output start, op_div, src_a, src_b, cancel, id_hilo_use,
    input  busy, stall, hilo_we, hi_o, lo_o
  );

  // Sequencer side.
  modport slave (
    input  start, op_div, src_a, src_b, cancel, id_hilo_use,
    output busy, stall, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULTU/DIVU sequencer: radix-2 shift-add multiply or restoring divide,
// one bit per cycle, finishing with a single-cycle HI/LO write strobe.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               op_div_q;
  logic [WIDTH-1:0]   b_q;
  // Shared datapath: MUL uses it as the product accumulator, DIV as {rem, quo}.
  logic [2*WIDTH:0]   acc_q;
  logic               hilo_we_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [2*WIDTH:0]   div_next;
  logic [2*WIDTH:0]   step_next;

  // One iteration of the selected algorithm, applied to the current datapath.
  always_comb begin
    mul_sum   = acc_q[2*WIDTH:WIDTH] + {1'b0, b_q};
    mul_next  = acc_q[0] ? {1'b0, mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH:1]};
    // Shift {rem, quo} left by one; the rem MSB is always 0 before the shift.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_next  = {(div_ge ? (div_shift - {1'b0, b_q}) : div_shift), acc_q[WIDTH-2:0], div_ge};
    step_next = op_div_q ? div_next : mul_next;
  end

  // Sequencer FSM with registered strobe and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_div_q  <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      hilo_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      hilo_we_q <= 1'b0;
      if (bus.cancel) begin
        // A strobe already showing in DONE is not retracted: it is this cycle's output.
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              op_div_q <= bus.op_div;
              b_q      <= bus.src_b;
              acc_q    <= {{(WIDTH+1){1'b0}}, bus.src_a};
              cnt_q    <= '0;
              if (bus.op_div && (bus.src_b == '0)) begin
                state_q   <= StDone;
                hilo_we_q <= 1'b1;
                hi_q      <= bus.src_a;
                lo_q      <= '1;
              end else begin
                state_q <= StCalc;
              end
            end
          end
          StCalc: begin
            acc_q <= step_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q   <= StDone;
              cnt_q     <= '0;
              hilo_we_q <= 1'b1;
              // Same slices serve both: product hi/lo or remainder/quotient.
              hi_q      <= step_next[2*WIDTH-1:WIDTH];
              lo_q      <= step_next[WIDTH-1:0];
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.busy    = (state_q != StIdle);
  // Combinational so an MFHI/MFLO directly behind the starting op is held too.
  assign bus.stall   = bus.id_hilo_use & ((state_q != StIdle) | bus.start);
  assign bus.hilo_we = hilo_we_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule
